// File: rtl/fp32_reduce_sum_seq_if.sv
//------------------------------------------------------------------------------
// fp32_reduce_sum_seq_if
// Element stream, sum stream and adder-side signals of the FP32 reduce sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp32_reduce_sum_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_vld;
  logic                  add_en;
  logic [DATA_WIDTH-1:0] add_res;
  logic                  add_res_vld;

  // Environment side: element source, sum sink and the adder.
  modport master (
    output in_data, in_valid, in_last, out_ready, add_res, add_res_vld,
    input  in_ready, out_data, out_valid, add_a, add_b, add_vld, add_en
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready, add_res, add_res_vld,
    output in_ready, out_data, out_valid, add_a, add_b, add_vld, add_en
  );
endinterface

`default_nettype wire

// File: rtl/fp32_reduce_sum_seq.sv
//------------------------------------------------------------------------------
// fp32_reduce_sum_seq
// Streaming FP32 sum reduction around an external pipelined adder; one sum per vector.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp32_reduce_sum_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_LAT    = 3,
  parameter int POOL_DEPTH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  fp32_reduce_sum_seq_if.slave bus
);

  localparam int PTR_W = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;
  localparam int CNT_W = $clog2(POOL_DEPTH + 1);
  localparam int INF_W = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [DATA_WIDTH-1:0] pool [POOL_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      pool_cnt;
  logic [INF_W-1:0]      inflight;

  logic [DATA_WIDTH-1:0] add_a_q;
  logic [DATA_WIDTH-1:0] add_b_q;
  logic                  add_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  in_ready;
  logic                  accept;
  logic                  res_push;
  logic                  in_push;
  logic [1:0]            pop_n;
  logic                  issue;
  logic                  latch_out;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head1;
  logic [PTR_W-1:0]      res_slot;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(POOL_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign in_ready = (state == S_ACCUM) && !rst;
  assign accept   = bus.in_valid && in_ready;
  // A result arriving with nothing outstanding belongs to a pre-reset add.
  assign res_push = bus.add_res_vld && (inflight != '0);
  assign head     = pool[rd_ptr];
  assign head1    = pool[ptr_inc(rd_ptr)];
  assign res_slot = in_push ? ptr_inc(wr_ptr) : wr_ptr;

  always_comb begin
    state_next = state;
    in_push    = 1'b0;
    pop_n      = 2'd0;
    issue      = 1'b0;
    latch_out  = 1'b0;
    op_a       = add_a_q;
    op_b       = add_b_q;
    case (state)
      S_ACCUM: begin
        if (accept) begin
          if (pool_cnt != '0) begin
            issue = 1'b1;
            op_a  = bus.in_data;
            op_b  = head;
            pop_n = 2'd1;
          end else begin
            in_push = 1'b1;
          end
          if (bus.in_last) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pool_cnt >= CNT_W'(2)) begin
          issue = 1'b1;
          op_a  = head;
          op_b  = head1;
          pop_n = 2'd2;
        end else if ((pool_cnt == CNT_W'(1)) && (inflight == '0) && !bus.add_res_vld) begin
          latch_out  = 1'b1;
          pop_n      = 2'd1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_next = S_ACCUM;
        end
      end
      default: begin
        state_next = S_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Storage is data-only; validity is tracked entirely by pool_cnt.
  always_ff @(posedge clk) begin
    if (in_push) begin
      pool[wr_ptr] <= bus.in_data;
    end
    if (res_push) begin
      pool[res_slot] <= bus.add_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pool_cnt <= '0;
      inflight <= '0;
    end else begin
      case (pop_n)
        2'd1:    rd_ptr <= ptr_inc(rd_ptr);
        2'd2:    rd_ptr <= ptr_inc(ptr_inc(rd_ptr));
        default: rd_ptr <= rd_ptr;
      endcase
      case ({in_push, res_push})
        2'b10, 2'b01: wr_ptr <= ptr_inc(wr_ptr);
        2'b11:        wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
        default:      wr_ptr <= wr_ptr;
      endcase
      pool_cnt <= pool_cnt + CNT_W'(in_push) + CNT_W'(res_push) - CNT_W'(pop_n);
      inflight <= inflight + INF_W'(issue) - INF_W'(res_push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      add_vld_q <= issue;
      if (issue) begin
        add_a_q <= op_a;
        add_b_q <= op_b;
      end
      if (latch_out) begin
        out_data_q <= head;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_vld   = add_vld_q;
  assign bus.add_en    = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_fp32_reduce_sum_seq.sv
//------------------------------------------------------------------------------
// tb_fp32_reduce_sum_seq
// Directed bench with a 3-stage behavioural FP32 adder attached to the sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp32_reduce_sum_seq;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   add_cnt;

  fp32_reduce_sum_seq_if #(.DATA_WIDTH(32)) bus ();

  fp32_reduce_sum_seq #(
    .DATA_WIDTH (32),
    .ADD_LAT    (3),
    .POOL_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact for the small normal values used here, so truncation is harmless.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Adder pipeline is deliberately not reset so that pre-reset results arrive late.
  logic [31:0] pd [3];
  logic        pv [3];
  always @(posedge clk) begin
    pv[0] <= bus.add_vld;
    pd[0] <= r2f(f2r(bus.add_a) + f2r(bus.add_b));
    pv[1] <= pv[0];
    pd[1] <= pd[0];
    pv[2] <= pv[1];
    pd[2] <= pd[1];
    if (bus.add_vld) add_cnt <= add_cnt + 1;
  end
  assign bus.add_res     = pd[2];
  assign bus.add_res_vld = pv[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] e [8];
    logic [31:0] exp;
    bit          toggle;
  } vec_t;

  task automatic send_vec(input vec_t v, input bit check_ready);
    int stall;
    int w;
    stall = 0;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      if (v.toggle && i > 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!bus.in_ready) stall++;
        @(negedge clk);
      end
      w = 0;
      while (!bus.in_ready && w < 300) begin
        if (i > 0) stall++;
        @(negedge clk);
        w++;
      end
      if (w >= 300) check({v.name, " in_ready timeout"}, 32'd1, 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = v.e[i];
      bus.in_last  = (i == v.n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (check_ready) check({v.name, " in_ready stalls"}, stall, 32'd0);
  endtask

  task automatic get_out(input string name, input logic [31:0] exp);
    int w;
    w = 0;
    while (!bus.out_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      check({name, " out_valid timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " out_data"}, bus.out_data, exp);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  vec_t tbl [6];
  vec_t v;
  int   a0;
  int   bad;

  initial begin
    tests = 0;
    fails = 0;
    add_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    tbl[0].name = "sum_1234";  tbl[0].n = 4; tbl[0].toggle = 1'b0; tbl[0].exp = 32'h41200000;
    tbl[0].e[0] = 32'h3F800000; tbl[0].e[1] = 32'h40000000;
    tbl[0].e[2] = 32'h40400000; tbl[0].e[3] = 32'h40800000;
    tbl[1].name = "eight_twos_toggle"; tbl[1].n = 8; tbl[1].toggle = 1'b1; tbl[1].exp = 32'h41800000;
    for (int i = 0; i < 8; i++) tbl[1].e[i] = 32'h40000000;
    tbl[2].name = "five_ones"; tbl[2].n = 5; tbl[2].toggle = 1'b0; tbl[2].exp = 32'h40A00000;
    for (int i = 0; i < 5; i++) tbl[2].e[i] = 32'h3F800000;
    tbl[3].name = "fractions"; tbl[3].n = 3; tbl[3].toggle = 1'b0; tbl[3].exp = 32'h3F800000;
    tbl[3].e[0] = 32'h3F000000; tbl[3].e[1] = 32'h3E800000; tbl[3].e[2] = 32'h3E800000;
    tbl[4].name = "three_ones_toggle"; tbl[4].n = 3; tbl[4].toggle = 1'b1; tbl[4].exp = 32'h40400000;
    for (int i = 0; i < 3; i++) tbl[4].e[i] = 32'h3F800000;
    tbl[5].name = "eight_mixed"; tbl[5].n = 8; tbl[5].toggle = 1'b0; tbl[5].exp = 32'h42100000;
    for (int i = 0; i < 8; i++) tbl[5].e[i] = (i % 2 == 0) ? 32'h3F800000 : 32'h41000000;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",  32'(bus.in_ready),  32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data",  bus.out_data,       32'd0);
    check("reset add_vld",   32'(bus.add_vld),   32'd0);
    check("reset add_a",     bus.add_a,          32'd0);
    check("reset add_b",     bus.add_b,          32'd0);
    check("reset add_en",    32'(bus.add_en),    32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    // Single-element latency: visible out_valid one edge after the DRAIN cycle.
    a0 = add_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40400000;
    bus.in_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("single out_valid early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("single out_valid", 32'(bus.out_valid), 32'd1);
    check("single out_data",  bus.out_data,       32'h40400000);
    @(posedge clk);
    @(negedge clk);
    check("single out_valid cleared", 32'(bus.out_valid), 32'd0);
    check("single add_vld count", add_cnt - a0, 32'd0);

    for (int t = 0; t < 6; t++) begin
      send_vec(tbl[t], 1'b1);
      get_out(tbl[t].name, tbl[t].exp);
    end

    // Backpressure: result must hold while the sink stalls.
    bus.out_ready = 1'b0;
    v.name = "hold"; v.n = 2; v.toggle = 1'b0; v.exp = 32'h40800000;
    v.e[0] = 32'h40000000; v.e[1] = 32'h40000000;
    send_vec(v, 1'b1);
    a0 = 0;
    while (!bus.out_valid && a0 < 300) begin
      @(negedge clk);
      a0++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold out_data",  bus.out_data,       32'h40800000);
      check("hold in_ready",  32'(bus.in_ready),  32'd0);
      check("hold out_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold release out_valid", 32'(bus.out_valid), 32'd0);
    check("hold release in_ready",  32'(bus.in_ready),  32'd1);

    // Reset while two adds are outstanding; their late results must vanish.
    v = tbl[0];
    v.name = "pre-reset";
    send_vec(v, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("post-reset no out_valid", bad, 32'd0);
    v.name = "after_reset"; v.n = 2; v.toggle = 1'b0; v.exp = 32'h40000000;
    v.e[0] = 32'h3F800000; v.e[1] = 32'h3F800000;
    send_vec(v, 1'b1);
    get_out(v.name, v.exp);

    // Two vectors queued back-to-back; sums must come out in order.
    fork
      begin
        vec_t va;
        vec_t vb;
        va.name = "b2b_a"; va.n = 2; va.toggle = 1'b0; va.exp = 32'h40400000;
        va.e[0] = 32'h3F800000; va.e[1] = 32'h40000000;
        vb.name = "b2b_b"; vb.n = 2; vb.toggle = 1'b0; vb.exp = 32'h41000000;
        vb.e[0] = 32'h40800000; vb.e[1] = 32'h40800000;
        send_vec(va, 1'b0);
        send_vec(vb, 1'b0);
      end
      begin
        get_out("b2b first",  32'h40400000);
        get_out("b2b second", 32'h41000000);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
